// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Pipeline stage between decode and execute. It reads two source registers
// from the register file and resolves each operand in priority order:
// the zero register, then the execute-stage result, then the writeback data,
// then the register-file data. A load still in execute whose destination
// feeds a used source stalls the stage. While stalled, the stage inserts a
// bubble downstream and counts the stall cycles.
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   in_valid / in_ready        handshake with decode
//   in_rn, in_rm, in_rd        source and destination register indices
//   in_use_rn, in_use_rm       marks which sources the instruction reads
//   in_reg_write, in_is_load   attributes of the decoded instruction
//   readRegA/B, readDataA/B    register-file read port
//   ex_*                       forwarding source from the execute stage
//   wb_*                       forwarding source from writeback
//   flush                      discards the output slot and blocks the input
//   out_valid / out_ready      handshake with execute
//   out_opA, out_opB           resolved operands
//   out_rd, out_reg_write,     destination and attributes forwarded
//   out_is_load                  to execute
//   stall_count                saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZR         = 31
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rn,
    input  logic [ADDR_WIDTH-1:0] in_rm,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_use_rn,
    input  logic                  in_use_rm,
    input  logic                  in_reg_write,
    input  logic                  in_is_load,

    output logic [ADDR_WIDTH-1:0] readRegA,
    output logic [ADDR_WIDTH-1:0] readRegB,
    input  logic [DATA_WIDTH-1:0] readDataA,
    input  logic [DATA_WIDTH-1:0] readDataB,

    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_load,
    input  logic [DATA_WIDTH-1:0] ex_result,

    input  logic                  wb_write,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,

    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_opA,
    output logic [DATA_WIDTH-1:0] out_opB,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_is_load,
    output logic [15:0]           stall_count
);

    localparam logic [ADDR_WIDTH-1:0] ZR_IDX = ADDR_WIDTH'(ZR);

    // Per-source views so that both operands share one resolution circuit.
    logic [ADDR_WIDTH-1:0] src_idx  [2];
    logic [DATA_WIDTH-1:0] rf_data  [2];
    logic [DATA_WIDTH-1:0] resolved [2];
    logic [1:0]            src_used;
    logic [1:0]            load_use;

    logic hazard;
    logic advance;
    logic take;

    assign readRegA = in_rn;
    assign readRegB = in_rm;

    assign src_idx[0]  = in_rn;
    assign src_idx[1]  = in_rm;
    assign rf_data[0]  = readDataA;
    assign rf_data[1]  = readDataB;
    assign src_used[0] = in_use_rn;
    assign src_used[1] = in_use_rm;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic not_zr;
            logic ex_hit;
            logic wb_hit;
            logic ld_hit;

            assign not_zr = (src_idx[gi] != ZR_IDX);
            // A load result is not available until after execute, so it is
            // never forwarded from ex; it stalls the consumer instead.
            assign ex_hit = ex_valid && ex_reg_write && !ex_is_load
                            && (ex_rd == src_idx[gi]) && not_zr;
            assign wb_hit = wb_write && (wb_rd == src_idx[gi]) && not_zr;
            assign ld_hit = ex_valid && ex_reg_write && ex_is_load
                            && (ex_rd == src_idx[gi]) && not_zr;

            assign resolved[gi] = !not_zr ? '0          :
                                  ex_hit  ? ex_result   :
                                  wb_hit  ? wb_data     :
                                            rf_data[gi];

            // Unused sources are resolved but can never stall the stage.
            assign load_use[gi] = src_used[gi] && ld_hit;
        end
    endgenerate

    assign hazard   = in_valid && (|load_use);
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !hazard && !flush;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_opA       <= '0;
            out_opB       <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_is_load   <= 1'b0;
        end else if (flush) begin
            // Only the valid bit is cleared; the data registers are don't-care.
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= take;
            if (take) begin
                out_opA       <= resolved[0];
                out_opB       <= resolved[1];
                out_rd        <= in_rd;
                // Writes to the zero register are architecturally discarded.
                out_reg_write <= in_reg_write && (in_rd != ZR_IDX);
                out_is_load   <= in_is_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (hazard && !flush && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//
// Directed bench for operand_fetch: forwarding priority, load-use stall,
// zero-register handling, backpressure, flush and asynchronous reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rn;
    logic [AW-1:0] in_rm;
    logic [AW-1:0] in_rd;
    logic          in_use_rn;
    logic          in_use_rm;
    logic          in_reg_write;
    logic          in_is_load;
    logic [AW-1:0] readRegA;
    logic [AW-1:0] readRegB;
    logic [DW-1:0] readDataA;
    logic [DW-1:0] readDataB;
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_is_load;
    logic [DW-1:0] ex_result;
    logic          wb_write;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_opA;
    logic [DW-1:0] out_opB;
    logic [AW-1:0] out_rd;
    logic          out_reg_write;
    logic          out_is_load;
    logic [15:0]   stall_count;

    int tests_run = 0;
    int fails     = 0;

    operand_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ZR         (31)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rn         (in_rn),
        .in_rm         (in_rm),
        .in_rd         (in_rd),
        .in_use_rn     (in_use_rn),
        .in_use_rm     (in_use_rm),
        .in_reg_write  (in_reg_write),
        .in_is_load    (in_is_load),
        .readRegA      (readRegA),
        .readRegB      (readRegB),
        .readDataA     (readDataA),
        .readDataB     (readDataB),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_is_load    (ex_is_load),
        .ex_result     (ex_result),
        .wb_write      (wb_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opA       (out_opA),
        .out_opB       (out_opB),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_is_load   (out_is_load),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) begin
            $display("[TB] %0t %s ok (%0h)", $time, tag, obs);
        end else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_rn = '0; in_rm = '0; in_rd = '0;
        in_use_rn = 1'b0; in_use_rm = 1'b0; in_reg_write = 1'b0; in_is_load = 1'b0;
        readDataA = '0; readDataB = '0;
        ex_valid = 1'b0; ex_rd = '0; ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_result = '0;
        wb_write = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        check("rst_opA", out_opA, 64'd0);
        tick();
        rst = 1'b1;

        // Forwarding priority on operand A
        in_valid = 1'b1; in_rn = 5'd3; in_rm = 5'd4; in_rd = 5'd8;
        in_use_rn = 1'b1; in_use_rm = 1'b1; in_reg_write = 1'b1; in_is_load = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd3; ex_reg_write = 1'b1; ex_is_load = 1'b0; ex_result = 64'h11;
        wb_write = 1'b1; wb_rd = 5'd3; wb_data = 64'h22;
        readDataA = 64'h33; readDataB = 64'h44;
        #1;
        check("readRegA", 64'(readRegA), 64'd3);
        check("readRegB", 64'(readRegB), 64'd4);
        check("fwd_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("fwd_ex_valid", 64'(out_valid), 64'd1);
        check("fwd_ex_opA", out_opA, 64'h11);
        check("fwd_ex_opB", out_opB, 64'h44);
        check("fwd_ex_rd", 64'(out_rd), 64'd8);
        check("fwd_ex_regw", 64'(out_reg_write), 64'd1);
        ex_valid = 1'b0;
        tick();
        check("fwd_wb_opA", out_opA, 64'h22);
        wb_write = 1'b0;
        tick();
        check("fwd_rf_opA", out_opA, 64'h33);
        in_rm = 5'd3; readDataB = 64'h33; wb_write = 1'b1; wb_data = 64'h55;
        tick();
        check("fwd_wb_opB", out_opB, 64'h55);
        wb_write = 1'b0;

        // Load-use stall
        in_rn = 5'd5; in_rm = 5'd6; readDataA = 64'h500; readDataB = 64'h600;
        ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_is_load = 1'b1; ex_result = 64'hDEAD;
        #1;
        check("ldu_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("ldu_bubble", 64'(out_valid), 64'd0);
        check("ldu_stall1", 64'(stall_count), 64'd1);
        ex_valid = 1'b0;
        #1;
        check("ldu_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("ldu_capture_valid", 64'(out_valid), 64'd1);
        check("ldu_capture_opA", out_opA, 64'h500);
        check("ldu_stall_hold", 64'(stall_count), 64'd1);

        // Unused source matching an in-flight load does not stall
        in_rn = 5'd6; in_rm = 5'd5; in_use_rm = 1'b0;
        ex_valid = 1'b1;
        #1;
        check("unused_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("unused_valid", 64'(out_valid), 64'd1);
        check("unused_opB", out_opB, 64'h600);
        check("unused_stall", 64'(stall_count), 64'd1);
        in_use_rm = 1'b1; ex_valid = 1'b0;

        // Zero register
        in_rn = 5'd31; in_rm = 5'd6; in_rd = 5'd31; in_reg_write = 1'b1;
        readDataA = 64'hAB;
        ex_valid = 1'b1; ex_rd = 5'd31; ex_reg_write = 1'b1; ex_is_load = 1'b0; ex_result = 64'hFF;
        wb_write = 1'b1; wb_rd = 5'd31; wb_data = 64'hFF;
        tick();
        check("zr_opA", out_opA, 64'd0);
        check("zr_regw", 64'(out_reg_write), 64'd0);
        check("zr_rd", 64'(out_rd), 64'd31);
        ex_is_load = 1'b1; in_rd = 5'd7; in_is_load = 1'b1;
        #1;
        check("zr_load_ready", 64'(in_ready), 64'd1);
        tick();
        check("zr_load_valid", 64'(out_valid), 64'd1);
        check("zr_load_stall", 64'(stall_count), 64'd1);
        check("rd7_regw", 64'(out_reg_write), 64'd1);
        check("rd7_is_load", 64'(out_is_load), 64'd1);
        ex_valid = 1'b0; ex_is_load = 1'b0; wb_write = 1'b0; in_is_load = 1'b0;

        // Backpressure
        in_rn = 5'd1; readDataA = 64'h100; in_rd = 5'd9;
        tick();
        check("bp_first_opA", out_opA, 64'h100);
        out_ready = 1'b0;
        in_rn = 5'd2; readDataA = 64'h200; in_rd = 5'd10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_opA", out_opA, 64'h100);
            check("bp_hold_rd", 64'(out_rd), 64'd9);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_new_opA", out_opA, 64'h200);
        check("bp_new_rd", 64'(out_rd), 64'd10);

        // Empty input inserts a bubble
        in_valid = 1'b0;
        tick();
        check("empty_bubble", 64'(out_valid), 64'd0);

        // Flush
        in_valid = 1'b1; in_rn = 5'd1; readDataA = 64'h100; in_rd = 5'd11;
        tick();
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        in_rn = 5'd2; readDataA = 64'h200; in_rd = 5'd12;
        flush = 1'b1; out_ready = 1'b0;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("fl_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_after_valid", 64'(out_valid), 64'd1);
        check("fl_after_opA", out_opA, 64'h200);
        check("fl_after_rd", 64'(out_rd), 64'd12);

        // Reset asserted in the middle of a stall with a held output
        out_ready = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd2; ex_reg_write = 1'b1; ex_is_load = 1'b1;
        tick();
        check("rs_stall2", 64'(stall_count), 64'd2);
        tick();
        check("rs_stall3", 64'(stall_count), 64'd3);
        check("rs_held_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_opA", out_opA, 64'd0);
        check("rs_opB", out_opB, 64'd0);
        check("rs_rd", 64'(out_rd), 64'd0);
        check("rs_regw", 64'(out_reg_write), 64'd0);
        check("rs_is_load", 64'(out_is_load), 64'd0);
        check("rs_stall", 64'(stall_count), 64'd0);
        ex_valid = 1'b0; ex_is_load = 1'b0; out_ready = 1'b1;
        in_rn = 5'd4; readDataA = 64'h400; in_rd = 5'd13;
        tick();
        check("rs_held_in_reset", 64'(out_valid), 64'd0);
        rst = 1'b1;
        tick();
        check("rs_first_valid", 64'(out_valid), 64'd1);
        check("rs_first_opA", out_opA, 64'h400);
        check("rs_first_rd", 64'(out_rd), 64'd13);
        check("rs_first_stall", 64'(stall_count), 64'd0);

        in_valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
